// File: rtl/effect_sequencer_if.sv
// Byte-stream handshake bundle between UART RX/TX, the clipping effect and the sequencer.
// The master modport is the sequencer side; slave is the surrounding environment.
interface effect_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       fx_valid;
    logic [7:0] fx_byte;
    logic [7:0] fx_result;
    logic [7:0] clip_level;
    logic       bypass;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       overrun;

    modport master (
        input  rx_valid, rx_byte, fx_result, tx_done,
        output fx_valid, fx_byte, clip_level, bypass, tx_start, tx_byte, overrun
    );

    modport slave (
        output rx_valid, rx_byte, fx_result, tx_done,
        input  fx_valid, fx_byte, clip_level, bypass, tx_start, tx_byte, overrun
    );
endinterface

// File: rtl/effect_sequencer.sv
// Splits the UART byte stream into samples and escape-framed commands, drives the
// clipping effect, and forwards results or status replies to the UART transmitter.
module effect_sequencer #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned EFF_LAT  = 1,
    parameter logic [7:0]  ESC_BYTE = 8'hFF,
    parameter logic [7:0]  CLIP_RST = 8'd200
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    effect_sequencer_if.master   bus
);

    if ((CLK_FREQ == 32'd0) || (EFF_LAT < 32'd1) || (EFF_LAT > 32'd15)) begin : g_param_check
        $error("effect_sequencer: CLK_FREQ must be nonzero and EFF_LAT in 1..15");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ESC     = 3'd1,
        ST_OP      = 3'd2,
        ST_FX_WAIT = 3'd3,
        ST_TX_GO   = 3'd4,
        ST_TX_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_CLIP = 2'd0,
        OP_BYP  = 2'd1,
        OP_ECHO = 2'd2
    } op_t;

    state_t     state_q,      state_d;
    op_t        op_q,         op_d;
    logic [3:0] cnt_q,        cnt_d;
    logic       fx_valid_q,   fx_valid_d;
    logic [7:0] fx_byte_q,    fx_byte_d;
    logic       tx_start_q,   tx_start_d;
    logic [7:0] tx_byte_q,    tx_byte_d;
    logic [7:0] clip_level_q, clip_level_d;
    logic       bypass_q,     bypass_d;
    logic       overrun_q,    overrun_d;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        fx_valid_d   = 1'b0;
        fx_byte_d    = fx_byte_q;
        tx_byte_d    = tx_byte_q;
        clip_level_d = clip_level_q;
        bypass_d     = bypass_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_byte == ESC_BYTE)) begin
                    state_d = ST_ESC;
                end else if (bus.rx_valid) begin
                    fx_byte_d  = bus.rx_byte;
                    fx_valid_d = 1'b1;
                    cnt_d      = 4'(EFF_LAT);
                    state_d    = ST_FX_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ESC: begin
                if (bus.rx_valid) begin
                    case (bus.rx_byte)
                        ESC_BYTE: begin
                            // Doubled escape is a literal 0xFF sample.
                            fx_byte_d  = bus.rx_byte;
                            fx_valid_d = 1'b1;
                            cnt_d      = 4'(EFF_LAT);
                            state_d    = ST_FX_WAIT;
                        end
                        8'h01: begin
                            op_d    = OP_CLIP;
                            state_d = ST_OP;
                        end
                        8'h02: begin
                            op_d    = OP_BYP;
                            state_d = ST_OP;
                        end
                        8'h04: begin
                            op_d    = OP_ECHO;
                            state_d = ST_OP;
                        end
                        8'h03: begin
                            tx_byte_d = {overrun_q, bypass_q, clip_level_q[7:2]};
                            state_d   = ST_TX_GO;
                        end
                        8'h05: begin
                            overrun_d = 1'b0;
                            state_d   = ST_IDLE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_ESC;
                end
            end
            ST_OP: begin
                if (bus.rx_valid) begin
                    case (op_q)
                        OP_CLIP: begin
                            clip_level_d = bus.rx_byte;
                            state_d      = ST_IDLE;
                        end
                        OP_BYP: begin
                            bypass_d = bus.rx_byte[0];
                            state_d  = ST_IDLE;
                        end
                        OP_ECHO: begin
                            tx_byte_d = clip_level_q;
                            state_d   = ST_TX_GO;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_OP;
                end
            end
            ST_FX_WAIT: begin
                if (cnt_q == 4'd0) begin
                    tx_byte_d = bypass_q ? fx_byte_q : bus.fx_result;
                    state_d   = ST_TX_GO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_TX_GO: begin
                state_d = ST_TX_WAIT;
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_TX_WAIT: begin
                if (bus.tx_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TX_WAIT;
                end
                if (bus.rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx_start is high for exactly the single cycle spent in TX_GO.
        tx_start_d = (state_d == ST_TX_GO);
    end

    // State and registered-output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_CLIP;
            cnt_q        <= 4'd0;
            fx_valid_q   <= 1'b0;
            fx_byte_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            clip_level_q <= CLIP_RST;
            bypass_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            fx_valid_q   <= fx_valid_d;
            fx_byte_q    <= fx_byte_d;
            tx_start_q   <= tx_start_d;
            tx_byte_q    <= tx_byte_d;
            clip_level_q <= clip_level_d;
            bypass_q     <= bypass_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.fx_valid   = fx_valid_q;
    assign bus.fx_byte    = fx_byte_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.clip_level = clip_level_q;
    assign bus.bypass     = bypass_q;
    assign bus.overrun    = overrun_q;

endmodule
